// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sram_ctrl_pkg
// Brief   : Shared state encoding, bus widths and decode helpers for sram_ctrl
// Rev     : 1.0  initial release
// ============================================================================
package sram_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD       = 3'd1,
        S_WR_SETUP = 3'd2,
        S_WR_PULSE = 3'd3,
        S_WR_HOLD  = 3'd4,
        S_DONE     = 3'd5
    } state_e;

    function automatic logic is_write_phase(input state_e s);
        return (s == S_WR_SETUP) || (s == S_WR_PULSE) || (s == S_WR_HOLD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : sram_ctrl_if
// Brief   : Single-word req/ack request bus between the memory stage and sram_ctrl
// Rev     : 1.0  initial release
// ============================================================================
interface sram_ctrl_if
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = 20
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              busy;

    modport master (output req, we, addr, be, wdata, input  rdata, ack, busy);
    modport slave  (input  req, we, addr, be, wdata, output rdata, ack, busy);
endinterface
`default_nettype wire

// File: rtl/sram_read_buf.sv
`default_nettype none
// ============================================================================
// Module  : sram_read_buf
// Brief   : One-entry read buffer (valid/addr/data) with hit compare; only
//           built when SRAM_CTRL_RDBUF_EN is defined
// Rev     : 1.0  initial release
// ============================================================================
`ifdef SRAM_CTRL_RDBUF_EN
module sram_read_buf
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = 20
)(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              fill_i,
    input  wire logic [ADDR_W-1:0] fill_addr_i,
    input  wire logic [DATA_W-1:0] fill_data_i,
    input  wire logic              inv_i,
    input  wire logic [ADDR_W-1:0] inv_addr_i,
    input  wire logic [ADDR_W-1:0] lookup_addr_i,
    output logic                   hit_o,
    output logic [DATA_W-1:0]      data_o
);
    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (fill_i) begin
            valid_q <= 1'b1;
            addr_q  <= fill_addr_i;
            data_q  <= fill_data_i;
        end else if (inv_i && (inv_addr_i == addr_q)) begin
            valid_q <= 1'b0;
        end
    end

    assign hit_o  = valid_q && (addr_q == lookup_addr_i);
    assign data_o = data_q;
endmodule
`endif
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sram_ctrl
// Brief   : Async SRAM initiator: req/ack word requests to ce_n/oe_n/we_n/be_n
// Config  : SRAM_CTRL_RDBUF_EN adds a one-entry read buffer (sram_read_buf)
// Rev     : 1.0  initial release
// ============================================================================
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 20
)(
    input  wire logic       clk,
    input  wire logic       rst,
    sram_ctrl_if.slave      bus,
    inout  wire [DATA_W-1:0] base_ram_data,
    output logic [ADDR_W-1:0] base_ram_addr,
    output logic [BE_W-1:0] base_ram_be_n,
    output logic            base_ram_ce_n,
    output logic            base_ram_oe_n,
    output logic            base_ram_we_n
);
    if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > 15)) begin : g_bad_wait
        $error("sram_ctrl: WAIT_CYCLES=%0d outside 1..15", WAIT_CYCLES);
    end

    localparam logic [CNT_W-1:0] C_RD_LAST = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] C_WR_LAST = CNT_W'(WAIT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic              ce_n_q, oe_n_q, we_n_q, dout_en_q;
    logic              ce_n_d, oe_n_d, we_n_d, dout_en_d;
    logic [BE_W-1:0]   be_n_q, be_n_d, be_sel;
    logic              w_accept, w_rd_last, w_hit, w_hit_take;
    logic [DATA_W-1:0] w_buf_data;

`ifdef SRAM_CTRL_RDBUF_EN
    sram_read_buf #(.ADDR_W(ADDR_W)) u_rdbuf (
        .clk           (clk),
        .rst           (rst),
        .fill_i        (w_rd_last),
        .fill_addr_i   (addr_q),
        .fill_data_i   (base_ram_data),
        .inv_i         (w_accept && bus.we),
        .inv_addr_i    (bus.addr),
        .lookup_addr_i (bus.addr),
        .hit_o         (w_hit),
        .data_o        (w_buf_data)
    );
`else
    assign w_hit      = 1'b0;
    assign w_buf_data = '0;
`endif

    assign w_rd_last  = (state_q == S_RD) && (cnt_q == C_RD_LAST);
    assign w_hit_take = w_accept && !bus.we && w_hit;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_accept = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    w_accept = 1'b1;
                    cnt_d    = '0;
                    if (bus.we)     state_d = S_WR_SETUP;
                    else if (w_hit) state_d = S_DONE;
                    else            state_d = S_RD;
                end
            end
            S_RD: begin
                if (cnt_q == C_RD_LAST) state_d = S_DONE;
                else                    cnt_d   = cnt_q + CNT_W'(1);
            end
            S_WR_SETUP: begin
                state_d = S_WR_PULSE;
                cnt_d   = '0;
            end
            S_WR_PULSE: begin
                if (cnt_q == C_WR_LAST) state_d = S_WR_HOLD;
                else                    cnt_d   = cnt_q + CNT_W'(1);
            end
            S_WR_HOLD: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Pin values are decoded from the next state so every SRAM pin leaves a flop.
    always_comb begin
        ce_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        we_n_d    = 1'b1;
        be_n_d    = '1;
        dout_en_d = 1'b0;
        be_sel    = w_accept ? bus.be : be_q;
        if (state_d == S_RD) begin
            ce_n_d = 1'b0;
            oe_n_d = 1'b0;
            be_n_d = '0;
        end else if (is_write_phase(state_d)) begin
            ce_n_d    = 1'b0;
            we_n_d    = (state_d != S_WR_PULSE);
            be_n_d    = ~be_sel;
            dout_en_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            be_n_q    <= '1;
            dout_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            be_n_q    <= be_n_d;
            dout_en_q <= dout_en_d;
            if (w_accept) begin
                addr_q  <= bus.addr;
                be_q    <= bus.be;
                wdata_q <= bus.wdata;
            end
            if (w_rd_last)       rdata_q <= base_ram_data;
            else if (w_hit_take) rdata_q <= w_buf_data;
        end
    end

    assign base_ram_data = dout_en_q ? wdata_q : {DATA_W{1'bz}};
    assign base_ram_addr = addr_q;
    assign base_ram_be_n = be_n_q;
    assign base_ram_ce_n = ce_n_q;
    assign base_ram_oe_n = oe_n_q;
    assign base_ram_we_n = we_n_q;

    assign bus.rdata = rdata_q;
    assign bus.ack   = (state_q == S_DONE);
    assign bus.busy  = (state_q != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_ctrl
// Brief   : Bench for sram_ctrl with WAIT_CYCLES 2/1/15 instances and SRAM models
// Rev     : 1.0  initial release
// ============================================================================
module tb_sram_ctrl;
    localparam int NI = 3;
`ifdef SRAM_CTRL_RDBUF_EN
    localparam bit RDBUF = 1'b1;
`else
    localparam bit RDBUF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NI-1:0] req_s, we_s, ack_s, busy_s, ce_n_s, oe_n_s, we_n_s;
    logic [19:0]   addr_s  [NI];
    logic [19:0]   paddr_s [NI];
    logic [3:0]    be_s    [NI];
    logic [3:0]    be_n_s  [NI];
    logic [31:0]   wdata_s [NI];
    logic [31:0]   rdata_s [NI];
    logic [31:0]   dbus_s  [NI];

    int total, bad;

    function automatic logic [31:0] init_word(input int a);
        return 32'hC0DE0000 + 32'(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] b);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int W = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
        sram_ctrl_if #(.ADDR_W(20)) bus ();
        wire [31:0]  dbus;
        logic [31:0] ram [4096];

        assign bus.req   = req_s[g];
        assign bus.we    = we_s[g];
        assign bus.addr  = addr_s[g];
        assign bus.be    = be_s[g];
        assign bus.wdata = wdata_s[g];
        assign ack_s[g]   = bus.ack;
        assign busy_s[g]  = bus.busy;
        assign rdata_s[g] = bus.rdata;
        assign dbus_s[g]  = dbus;

        sram_ctrl #(.WAIT_CYCLES(W), .ADDR_W(20)) u_dut (
            .clk           (clk),
            .rst           (rst),
            .bus           (bus),
            .base_ram_data (dbus),
            .base_ram_addr (paddr_s[g]),
            .base_ram_be_n (be_n_s[g]),
            .base_ram_ce_n (ce_n_s[g]),
            .base_ram_oe_n (oe_n_s[g]),
            .base_ram_we_n (we_n_s[g])
        );

        // SRAM responder plus a zero keeper while the chip is deselected.
        assign dbus = ce_n_s[g] ? 32'h0 : (!oe_n_s[g] ? ram[paddr_s[g][11:0]] : 32'hz);
        initial for (int i = 0; i < 4096; i++) ram[i] = init_word(i);
        always @(posedge clk)
            if (!ce_n_s[g] && !we_n_s[g])
                ram[paddr_s[g][11:0]] <= merge(ram[paddr_s[g][11:0]], dbus, ~be_n_s[g]);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int g = 0; g < NI; g++) begin
                chk("oe_we_both_low", 32'(!oe_n_s[g] && !we_n_s[g]), 32'd0);
                if (ce_n_s[g]) chk("bus_not_z", dbus_s[g], 32'd0);
            end
        end
    end

    task automatic txn(input int g, input logic w, input logic [19:0] a, input logic [3:0] b,
                       input logic [31:0] d, output int cyc, output logic [31:0] rd,
                       output logic saw_ce);
        @(negedge clk);
        we_s[g] = w; addr_s[g] = a; be_s[g] = b; wdata_s[g] = d; req_s[g] = 1'b1;
        cyc = 0; rd = '0; saw_ce = 1'b0;
        while (cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (!ce_n_s[g]) saw_ce = 1'b1;
            if (ack_s[g]) begin
                rd = rdata_s[g];
                break;
            end
        end
        req_s[g] = 1'b0;
    endtask

    // Reference model of instance 0: word memory, rdata hold value, buffer entry.
    logic [31:0] model [int];
    logic [31:0] last_rd;
    logic        buf_valid;
    logic [19:0] buf_addr;

    function automatic logic [31:0] mget(input logic [19:0] a);
        return model.exists(int'(a)) ? model[int'(a)] : init_word(int'(a[11:0]));
    endfunction

    task automatic run0(input logic w, input logic [19:0] a, input logic [3:0] b,
                        input logic [31:0] d, output int cyc, output logic [31:0] rd,
                        output logic saw_ce, output logic [31:0] exp_rd, output int exp_cyc);
        logic hit;
        hit     = RDBUF && !w && buf_valid && (buf_addr == a);
        exp_cyc = w ? 5 : (hit ? 1 : 4);
        exp_rd  = w ? last_rd : mget(a);
        txn(0, w, a, b, d, cyc, rd, saw_ce);
        chk("busy_at_ack", 32'(busy_s[0]), 32'd1);
        @(posedge clk); #1;
        chk("ack_one_cycle", 32'(ack_s[0]), 32'd0);
        chk("busy_after_ack", 32'(busy_s[0]), 32'd0);
        if (w) begin
            model[int'(a)] = merge(mget(a), d, b);
            if (buf_valid && buf_addr == a) buf_valid = 1'b0;
        end else begin
            last_rd = exp_rd; buf_valid = 1'b1; buf_addr = a;
        end
    endtask

    typedef struct {
        logic        w;
        logic [19:0] a;
        logic [3:0]  b;
        logic [31:0] d;
        logic [31:0] er;
        int          ecyc;
    } vec_t;
    vec_t tv [7];

    initial begin
        int cyc, ecyc, k;
        logic [31:0] rd, erd, prev;
        logic saw;
        int ack_at [3];

        tv[0] = '{1'b1, 20'h00010, 4'hF, 32'hDEADBEEF, 32'h0,         5};
        tv[1] = '{1'b0, 20'h00010, 4'h0, 32'h0,        32'hDEADBEEF,  4};
        tv[2] = '{1'b1, 20'h00020, 4'hF, 32'h11223344, 32'h0,         5};
        tv[3] = '{1'b1, 20'h00020, 4'h2, 32'h0000AA00, 32'h0,         5};
        tv[4] = '{1'b0, 20'h00020, 4'h0, 32'h0,        32'h1122AA44,  4};
        tv[5] = '{1'b1, 20'h00030, 4'h0, 32'hFFFFFFFF, 32'h0,         5};
        tv[6] = '{1'b0, 20'h00030, 4'h0, 32'h0,        32'hC0DE0030,  4};

        total = 0; bad = 0; rst = 1'b1;
        req_s = '0; we_s = '0;
        for (int g = 0; g < NI; g++) begin
            addr_s[g] = '0; be_s[g] = '0; wdata_s[g] = '0;
        end
        last_rd = '0; buf_valid = 1'b0; buf_addr = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ce_n", 32'(ce_n_s[0]), 32'd1);
        chk("rst_oe_n", 32'(oe_n_s[0]), 32'd1);
        chk("rst_we_n", 32'(we_n_s[0]), 32'd1);
        chk("rst_be_n", 32'(be_n_s[0]), 32'hF);
        chk("rst_addr", 32'(paddr_s[0]), 32'd0);
        chk("rst_ack", 32'(ack_s[0]), 32'd0);
        chk("rst_busy", 32'(busy_s[0]), 32'd0);
        chk("rst_rdata", rdata_s[0], 32'd0);
        chk("rst_bus", dbus_s[0], 32'd0);
        rst = 1'b0;

        prev = '0;
        for (int i = 0; i < 7; i++) begin
            run0(tv[i].w, tv[i].a, tv[i].b, tv[i].d, cyc, rd, saw, erd, ecyc);
            chk(tv[i].w ? "tv_wr_ack_cycle" : "tv_rd_ack_cycle", 32'(cyc), 32'(tv[i].ecyc));
            if (tv[i].w) chk("tv_rdata_held", rd, prev);
            else begin
                chk("tv_rdata", rd, tv[i].er);
                prev = tv[i].er;
            end
        end

        // req held high over three reads: one idle cycle between DONE and next accept
        @(negedge clk);
        we_s[0] = 1'b0; addr_s[0] = 20'h00001; req_s[0] = 1'b1;
        k = 0; cyc = 0;
        while (k < 3 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (ack_s[0]) begin
                ack_at[k] = cyc;
                chk("b2b_rdata", rdata_s[0], init_word(k + 1));
                k++;
                if (k < 3) addr_s[0] = 20'(k + 1);
            end
        end
        req_s[0] = 1'b0;
        chk("b2b_ack_count", 32'(k), 32'd3);
        for (int j = 0; j < k; j++) chk("b2b_ack_cycle", 32'(ack_at[j]), 32'(4 + 5 * j));
        last_rd = init_word(3); buf_valid = 1'b1; buf_addr = 20'h00003;
        @(posedge clk); #1;

`ifdef SRAM_CTRL_RDBUF_EN
        run0(1'b0, 20'h00040, 4'h0, 32'h0, cyc, rd, saw, erd, ecyc);
        chk("buf_miss_cycle", 32'(cyc), 32'd4);
        chk("buf_miss_ce", 32'(saw), 32'd1);
        run0(1'b0, 20'h00040, 4'h0, 32'h0, cyc, rd, saw, erd, ecyc);
        chk("buf_hit_cycle", 32'(cyc), 32'd1);
        chk("buf_hit_ce", 32'(saw), 32'd0);
        chk("buf_hit_rdata", rd, 32'hC0DE0040);
        run0(1'b1, 20'h00041, 4'hF, 32'h77, cyc, rd, saw, erd, ecyc);
        run0(1'b0, 20'h00040, 4'h0, 32'h0, cyc, rd, saw, erd, ecyc);
        chk("buf_other_wr_hit", 32'(cyc), 32'd1);
        run0(1'b1, 20'h00040, 4'hF, 32'h5, cyc, rd, saw, erd, ecyc);
        run0(1'b0, 20'h00040, 4'h0, 32'h0, cyc, rd, saw, erd, ecyc);
        chk("buf_inv_cycle", 32'(cyc), 32'd4);
        chk("buf_inv_ce", 32'(saw), 32'd1);
        chk("buf_inv_rdata", rd, 32'h5);
`endif

        // Reset during the second WR_PULSE cycle
        @(negedge clk);
        we_s[0] = 1'b1; addr_s[0] = 20'h00300; be_s[0] = 4'hF;
        wdata_s[0] = 32'hCAFEF00D; req_s[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("pulse_we_n", 32'(we_n_s[0]), 32'd0);
        #1 rst = 1'b1; req_s[0] = 1'b0;
        #1;
        chk("abort_ce_n", 32'(ce_n_s[0]), 32'd1);
        chk("abort_we_n", 32'(we_n_s[0]), 32'd1);
        chk("abort_oe_n", 32'(oe_n_s[0]), 32'd1);
        chk("abort_be_n", 32'(be_n_s[0]), 32'hF);
        chk("abort_bus", dbus_s[0], 32'd0);
        chk("abort_ack", 32'(ack_s[0]), 32'd0);
        chk("abort_rdata", rdata_s[0], 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_busy", 32'(busy_s[0]), 32'd0);
        chk("post_rst_ack", 32'(ack_s[0]), 32'd0);
        last_rd = '0; buf_valid = 1'b0;
        run0(1'b0, 20'h00010, 4'h0, 32'h0, cyc, rd, saw, erd, ecyc);
        chk("post_rst_rd_cycle", 32'(cyc), 32'd4);
        chk("post_rst_rdata", rd, 32'hDEADBEEF);

        for (int i = 0; i < 60; i++) begin
            logic w;
            logic [19:0] a;
            logic [3:0] b;
            logic [31:0] d;
            w = 1'($urandom_range(0, 1));
            a = 20'h00400 + 20'($urandom_range(0, 7));
            b = 4'($urandom_range(0, 15));
            d = $urandom;
            run0(w, a, b, d, cyc, rd, saw, erd, ecyc);
            chk(w ? "rnd_wr_cycle" : "rnd_rd_cycle", 32'(cyc), 32'(ecyc));
            chk(w ? "rnd_rdata_held" : "rnd_rdata", rd, erd);
        end

        for (int g = 1; g < NI; g++) begin
            int wv;
            wv = (g == 1) ? 1 : 15;
            txn(g, 1'b1, 20'h00010, 4'hF, 32'hDEADBEEF, cyc, rd, saw);
            chk("wait_wr_cycle", 32'(cyc), 32'(wv + 3));
            @(posedge clk); #1;
            txn(g, 1'b0, 20'h00010, 4'h0, 32'h0, cyc, rd, saw);
            chk("wait_rd_cycle", 32'(cyc), 32'(wv + 2));
            chk("wait_rdata", rd, 32'hDEADBEEF);
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
